// File: rtl/edge_pkg.sv
// Shared types and constants for the Sobel edge pipeline.
// Window indexing: element k = 3*row + col, row 0 / col 0 oldest.
package edge_pkg;

    localparam int PIX_W  = 8;

    localparam int WIN_TL = 0;
    localparam int WIN_C  = 4;
    localparam int WIN_BR = 8;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage, single port at a common address.
// Read is combinational and returns the value from before this cycle's write.
module line_buffer #(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator for the Sobel operator, one window per interior pixel.
// Define WIN_COORD_EN to add the registered centre coordinates out_x/out_y.
module sobel_window_gen #(
    parameter  int IMG_W = 256,
    parameter  int IMG_H = 256,
    parameter  int PIX_W = edge_pkg::PIX_W,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pixel,
    input  logic               in_sof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] out_win,
    output logic               out_eof
`ifdef WIN_COORD_EN
    ,
    output logic [CW-1:0]      out_x,
    output logic [RW-1:0]      out_y
`endif
);

    import edge_pkg::*;

    logic               accept;
    logic               emit;
    logic [CW-1:0]      col_q, col_d, ecol;
    logic [RW-1:0]      row_q, row_d, erow;
    logic [PIX_W-1:0]   lb0_rd, lb1_rd;
    logic [3*PIX_W-1:0] newcol;
    logic [9*PIX_W-1:0] win_q, win_d;
    logic               out_valid_q, out_valid_d;
    logic [9*PIX_W-1:0] out_win_q;
    logic               out_eof_q;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_win   = out_win_q;
    assign out_eof   = out_eof_q;

    // Start of frame overrides whatever position the counters hold.
    assign ecol = in_sof ? '0 : col_q;
    assign erow = in_sof ? '0 : row_q;
    assign emit = accept && (ecol >= CW'(2)) && (erow >= RW'(2));

    assign newcol = {in_pixel, lb1_rd, lb0_rd};

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (ecol == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = (erow == RW'(IMG_H-1)) ? '0 : erow + 1'b1;
            end else begin
                col_d = ecol + 1'b1;
                row_d = erow;
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[PIX_W*(3*r)   +: PIX_W] = win_q[PIX_W*(3*r+1) +: PIX_W];
                win_d[PIX_W*(3*r+1) +: PIX_W] = win_q[PIX_W*(3*r+2) +: PIX_W];
                win_d[PIX_W*(3*r+2) +: PIX_W] = newcol[PIX_W*r +: PIX_W];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (emit) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (ecol),
        .wdata (in_pixel),
        .rdata (lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (ecol),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_win_q   <= '0;
            out_eof_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            if (emit) begin
                out_win_q <= win_d;
                out_eof_q <= (ecol == CW'(IMG_W-1)) && (erow == RW'(IMG_H-1));
            end
        end
    end

`ifdef WIN_COORD_EN
    logic [CW-1:0] x_q;
    logic [RW-1:0] y_q;

    assign out_x = x_q;
    assign out_y = y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (emit) begin
            x_q <= ecol - 1'b1;
            y_q <= erow - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: 4x4 frames plus a 5x3 instance.
// Optional coordinate checks appear when WIN_COORD_EN is defined.
module tb_sobel_window_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [7:0]  in_pixel = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic        out_eof;
    logic [71:0] out_win;

    logic        v5 = 1'b0;
    logic        s5 = 1'b0;
    logic [7:0]  p5 = '0;
    logic        ordy5 = 1'b1;
    logic        irdy5;
    logic        ov5;
    logic        oe5;
    logic [71:0] ow5;

`ifdef WIN_COORD_EN
    logic [1:0]  out_x, out_y;
    logic [2:0]  x5;
    logic [1:0]  y5;
`endif

    typedef struct {
        logic [71:0] w;
        logic        eof;
        int          x;
        int          y;
    } rec_t;

    rec_t q[$];
    rec_t q5[$];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .out_eof   (out_eof)
`ifdef WIN_COORD_EN
        ,
        .out_x     (out_x),
        .out_y     (out_y)
`endif
    );

    sobel_window_gen #(.IMG_W(5), .IMG_H(3), .PIX_W(8)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v5),
        .in_ready  (irdy5),
        .in_pixel  (p5),
        .in_sof    (s5),
        .out_valid (ov5),
        .out_ready (ordy5),
        .out_win   (ow5),
        .out_eof   (oe5)
`ifdef WIN_COORD_EN
        ,
        .out_x     (x5),
        .out_y     (y5)
`endif
    );

    always @(negedge clk) begin
        rec_t r;
        if (rst_n && out_valid && out_ready) begin
            r.w = out_win;
            r.eof = out_eof;
            r.x = -1;
            r.y = -1;
`ifdef WIN_COORD_EN
            r.x = int'(out_x);
            r.y = int'(out_y);
`endif
            q.push_back(r);
        end
        if (rst_n && ov5 && ordy5) begin
            r.w = ow5;
            r.eof = oe5;
            r.x = -1;
            r.y = -1;
`ifdef WIN_COORD_EN
            r.x = int'(x5);
            r.y = int'(y5);
`endif
            q5.push_back(r);
        end
    end

    task automatic check(string tag, logic [71:0] got, logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [71:0] exp_win(int base, int w, int cx, int cy);
        logic [71:0] e;
        e = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                e[8*(3*r+c) +: 8] = 8'(base + (cy-1+r)*w + (cx-1+c));
            end
        end
        return e;
    endfunction

    task automatic send(logic [7:0] p, logic s);
        int t;
        in_valid = 1'b1;
        in_pixel = p;
        in_sof = s;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send5(logic [7:0] p, logic s);
        int t;
        v5 = 1'b1;
        p5 = p;
        s5 = s;
        t = 0;
        @(negedge clk);
        while (!irdy5 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("send5_timeout", 0, 1);
        @(posedge clk);
        #1;
        v5 = 1'b0;
        s5 = 1'b0;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        in_sof = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(int base);
        for (int i = 0; i < 16; i++) send(8'(base + i), i == 0);
    endtask

    task automatic check_frame(string tag, int base, int first);
        int cx, cy;
        for (int k = 0; k < 4; k++) begin
            cx = 1 + k % 2;
            cy = 1 + k / 2;
            if (first + k < q.size()) begin
                check($sformatf("%s_w%0d", tag, k), q[first+k].w,
                      exp_win(base, 4, cx, cy));
                check($sformatf("%s_eof%0d", tag, k), q[first+k].eof, k == 3);
`ifdef WIN_COORD_EN
                check($sformatf("%s_x%0d", tag, k), q[first+k].x, cx);
                check($sformatf("%s_y%0d", tag, k), q[first+k].y, cy);
`endif
            end else begin
                check($sformatf("%s_missing%0d", tag, k), 0, 1);
            end
        end
    endtask

    initial begin
        logic [71:0] first_w, last_w, f2_w;
        first_w = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        last_w  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
        f2_w    = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104,
                   8'd102, 8'd101, 8'd100};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_win", out_win, 0);
        check("rst_eof", out_eof, 0);
        @(posedge clk);
        #1;

        // 1: plain frame, first-window latency and contents
        q.delete();
        for (int i = 0; i < 16; i++) begin
            send(8'(i), i == 0);
            if (i == 10) begin
                check("t1_lat_valid", out_valid, 1);
                check("t1_lat_win", out_win, first_w);
`ifdef WIN_COORD_EN
                check("t1_lat_x", out_x, 1);
                check("t1_lat_y", out_y, 1);
`endif
            end
        end
        idle(3);
        check("t1_count", q.size(), 4);
        if (q.size() == 4) begin
            check("t1_first", q[0].w, first_w);
            check("t1_last", q[3].w, last_w);
            check("t1_last_eof", q[3].eof, 1);
        end
        check_frame("t1", 0, 0);

        // 2: backpressure after the first window
        q.delete();
        for (int i = 0; i < 11; i++) send(8'(i), i == 0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pixel = 8'd11;
        in_sof = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t2_stall_ready", in_ready, 0);
            check("t2_stall_win", out_win, exp_win(0, 4, 1, 1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 11; i < 16; i++) send(8'(i), 1'b0);
        idle(3);
        check("t2_count", q.size(), 4);
        check_frame("t2", 0, 0);

        // 3: back-to-back frames
        q.delete();
        frame(0);
        frame(100);
        idle(3);
        check("t3_count", q.size(), 8);
        if (q.size() > 4) check("t3_f2_first", q[4].w, f2_w);
        check_frame("t3a", 0, 0);
        check_frame("t3b", 100, 4);

        // 4: sof arriving mid-frame resynchronises
        q.delete();
        for (int i = 0; i < 6; i++) send(8'(50 + i), i == 0);
        frame(200);
        idle(3);
        check("t4_count", q.size(), 4);
        check_frame("t4", 200, 0);

        // 5: async reset with a pending window
        for (int i = 0; i < 11; i++) send(8'(i), i == 0);
        out_ready = 1'b0;
        check("t5_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_win", out_win, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        frame(20);
        idle(3);
        check("t5_count", q.size(), 4);
        check_frame("t5", 20, 0);

        // 6: 5x3 frame with gaps on in_valid
        q5.delete();
        for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send5(8'(i), i == 0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("t6_count", q5.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < q5.size()) begin
                check($sformatf("t6_w%0d", k), q5[k].w, exp_win(0, 5, 1 + k, 1));
                check($sformatf("t6_eof%0d", k), q5[k].eof, k == 2);
`ifdef WIN_COORD_EN
                check($sformatf("t6_x%0d", k), q5[k].x, 1 + k);
                check($sformatf("t6_y%0d", k), q5[k].y, 1);
`endif
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Builds 3x3 pixel neighbourhoods for the Sobel edge operator from a raster-order grayscale pixel stream. It sits directly downstream of the image fetch stage, which streams frame pixels one per accepted cycle. It feeds the gradient stage. Two internal line buffers hold the previous two image rows. One window is emitted for every interior pixel, so each frame produces (IMG_W-2)*(IMG_H-2) windows.

## Interface
- IMG_W, 256: pixels per row; must be ≥ 3.
- IMG_H, 256: rows per frame; must be ≥ 3.
- PIX_W, 8: bits per pixel.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream pixel is present.
- in_ready  out  1  the block accepts a pixel this cycle.
- in_pixel  in  PIX_W  pixel value, raster order.
- in_sof  in  1  start of frame; qualifies the pixel at (0,0).
- out_valid  out  1  out_win holds a valid window.
- out_ready  in  1  downstream accepts the window.
- out_win  out  9*PIX_W  window; element k = 3*r+c occupies bits [PIX_W*k +: PIX_W]. r=0 is the oldest (top) row and c=0 is the oldest (left) column, so k=4 is the centre and k=8 is the newest pixel.
- out_x  out  $clog2(IMG_W)  centre column (only when WIN_COORD_EN is defined).
- out_y  out  $clog2(IMG_H)  centre row (only when WIN_COORD_EN is defined).
- out_eof  out  1  marks the last window of a frame, with centre (IMG_W-2, IMG_H-2).

## Operation
- **Accept and counters**
  - A pixel is accepted when in_valid && in_ready.
  - Column counter col runs 0..IMG_W-1. Row counter row runs 0..IMG_H-1.
  - Both counters advance only on accept.
  - At (IMG_W-1, IMG_H-1) both counters wrap to 0.
  - An accept with in_sof=1 treats the pixel as (0,0), whatever the counter values are, and resynchronises the counters.
- **Line buffers**
  - On accept, line buffer LB1 is read at address col and gives the pixel one row above. LB0 at col gives the pixel two rows above.
  - Writes: LB1[col] ← in_pixel and LB0[col] ← old LB1[col]. Reads return the pre-write value (read-before-write).
- **Window shift**
  - On accept, each window row shifts left by one column.
  - The new right column is {LB0 read, LB1 read, in_pixel} for rows r=0, 1, 2.
- **Emit rule**
  - An accept at (col ≥ 2, row ≥ 2) loads the output register. The emitted window is centred at (col-1, row-1).
  - Accepts with col < 2 or row < 2 only update the shift and buffer state; no window is emitted.
- **Output register**
  - out_valid sets when a window is loaded.
  - out_valid clears when out_ready is high and no new window is loaded in the same cycle.
  - in_ready = !out_valid || out_ready, so there is a single output skid stage.
  - out_eof = 1 when the loaded centre is (IMG_W-2, IMG_H-2).
- **Reset values**
  - out_valid=0, out_win=0, out_eof=0, col=0, row=0, window registers=0.
  - out_x and out_y = 0 when present.
  - in_ready=1 after reset.
  - Line buffer contents are not reset. They never reach the output, because rows 0–1 are never emitted.

## Timing
- Latency from the accept of pixel (x,y) to out_valid for centre (x-1,y-1) is 1 cycle.
- Sustained throughput is 1 window per cycle when out_ready is held high.
- While out_valid && !out_ready, in_ready=0 and all state holds. out_win, out_x/out_y and out_eof stay stable until the transfer completes.
- Load and drain in the same cycle: out_valid stays 1 and the output takes the new window.
- An asynchronous reset mid-frame drops any pending window. The next frame must begin with in_sof.
- There is no bubble at a row boundary: the pixel at col 0 is accepted on the cycle after col IMG_W-1.

## Configuration
- `WIN_COORD_EN` defined:
  - out_x and out_y ports exist.
  - They are registered alongside out_win and equal the centre coordinates.
- Not defined:
  - The ports and their registers are absent.
  - All other behaviour is identical.

## Structure
- Shared package `edge_pkg`:
  - PIX_W default.
  - Window index constants: WIN_TL=0, WIN_C=4, WIN_BR=8.
  - Typedef pix_t (logic [PIX_W-1:0]).
- Sub-module `line_buffer`:
  - Parameters DEPTH and WIDTH; single write/read port at a common address.
  - Read-before-write; behavioural array that infers distributed or block RAM.
  - Instantiated twice, as LB0 and LB1.

## Test plan
All scenarios use IMG_W=4 and IMG_H=4 unless noted.
1. Stream pixels 0..15 with in_sof on pixel 0 and out_ready=1 → exactly 4 windows.
   - First window: {0,1,2,4,5,6,8,9,10}, centre (1,1), emitted 1 cycle after pixel 10 is accepted.
   - Last window: {5,6,7,9,10,11,13,14,15}, centre (2,2), with out_eof=1.
2. Hold out_ready=0 after the first window → in_ready=0 and out_win stays stable. Release after 5 cycles → the remaining windows arrive in order with no loss or duplication.
3. Two back-to-back frames (values 0..15, then 100..115) → the second frame's first window is {100,101,102,104,105,106,108,109,110}. No window contains a mix of values from the two frames.
4. Assert in_sof at pixel index 6 of a frame, then send 16 pixels → counters resync. Windows match a fresh frame starting at that pixel.
5. Pulse rst_n low mid-frame, while out_valid=1 → out_valid=0 immediately. After release, a new frame with in_sof produces correct windows.
6. With WIN_COORD_EN and IMG_W=5, IMG_H=3, randomly toggling in_valid → 3 windows with out_x=1,2,3 and out_y=1 for each.
